// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state encoding and parity-type constants for the UART TX frame engine
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: frame request, configuration and line/status signals between a TX source and the frame engine
interface uart_tx_frame_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
);

    logic [WIDTH-1:0]      p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
    logic                  msb_first;
    logic [PRESCALE_W-1:0] prescale;
    logic                  tx_out;
    logic                  busy;
    logic                  done;

    modport master (
        output p_data, data_valid, par_en, par_typ, stop2, msb_first, prescale,
        input  tx_out, busy, done
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ, stop2, msb_first, prescale,
        output tx_out, busy, done
    );

endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts clock cycles within one bit period and flags its last cycle
module uart_bit_timer #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_clear,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_bit_end,
    output logic                  o_bit_end_nxt
);

    logic [PRESCALE_W-1:0] r_cnt;
    logic [PRESCALE_W-1:0] w_cnt_nxt;

    // The counter restarts at every bit boundary, so it never wraps inside a bit.
    assign o_bit_end     = i_en && (r_cnt == i_prescale);
    assign w_cnt_nxt     = (i_clear || !i_en || o_bit_end) ? '0 : r_cnt + 1'b1;
    // Lets the frame engine register a pulse that lines up with the coming last cycle.
    assign o_bit_end_nxt = (w_cnt_nxt == i_prescale);

    // Cycle-within-bit counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_cnt <= '0;
        else          r_cnt <= w_cnt_nxt;
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises a parallel word into start, data, optional parity and one or two stop bits
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input logic            i_clk,
    input logic            i_rst_n,
    uart_tx_frame_if.slave s_bus
);

    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t                r_state, w_state;
    logic                  r_tx, w_tx;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic [WIDTH-1:0]      r_shift, w_shift, w_shifted;
    logic [IDX_W-1:0]      r_idx, w_idx;
    logic                  r_stop_cnt, w_stop_cnt;
    logic                  w_accept;
    logic                  r_par_en, r_parity, r_stop2, r_msb;
    logic [PRESCALE_W-1:0] r_pre;
    logic                  w_bit_end, w_bit_end_nxt;

    uart_bit_timer #(.PRESCALE_W(PRESCALE_W)) u_timer (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (r_busy),
        .i_clear       (w_accept),
        .i_prescale    (r_pre),
        .o_bit_end     (w_bit_end),
        .o_bit_end_nxt (w_bit_end_nxt)
    );

    assign w_shifted = r_msb ? (r_shift << 1) : (r_shift >> 1);

    // Next-state and next-output logic; the line value for each bit is set on entry to it.
    always_comb begin
        w_state    = r_state;
        w_tx       = r_tx;
        w_busy     = r_busy;
        w_shift    = r_shift;
        w_idx      = r_idx;
        w_stop_cnt = r_stop_cnt;
        w_accept   = 1'b0;
        case (r_state)
            IDLE:   w_accept = s_bus.data_valid;
            START:  if (w_bit_end) begin
                        w_state = DATA;
                        w_tx    = r_msb ? r_shift[WIDTH-1] : r_shift[0];
                    end
            DATA:   if (w_bit_end) begin
                        if (r_idx == LAST_IDX) begin
                            w_state    = r_par_en ? PARITY : STOP;
                            w_tx       = r_par_en ? r_parity : 1'b1;
                            w_stop_cnt = 1'b0;
                        end else begin
                            w_idx   = r_idx + 1'b1;
                            w_shift = w_shifted;
                            w_tx    = r_msb ? w_shifted[WIDTH-1] : w_shifted[0];
                        end
                    end
            PARITY: if (w_bit_end) begin
                        w_state    = STOP;
                        w_tx       = 1'b1;
                        w_stop_cnt = 1'b0;
                    end
            STOP:   if (w_bit_end) begin
                        if (r_stop2 && !r_stop_cnt) begin
                            w_stop_cnt = 1'b1;
                        end else begin
                            w_state  = IDLE;
                            w_busy   = 1'b0;
                            w_tx     = 1'b1;
                            w_accept = s_bus.data_valid;
                        end
                    end
            default: begin
                        w_state = IDLE;
                        w_busy  = 1'b0;
                        w_tx    = 1'b1;
                    end
        endcase
        if (w_accept) begin
            w_state    = START;
            w_tx       = 1'b0;
            w_busy     = 1'b1;
            w_shift    = s_bus.p_data;
            w_idx      = '0;
            w_stop_cnt = 1'b0;
        end
        // Done marks the last cycle of the final stop bit, so a request seen then starts the next frame gaplessly.
        w_done = (w_state == STOP) && (!r_stop2 || w_stop_cnt) && w_bit_end_nxt;
    end

    // State, shift register, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_shift    <= '0;
            r_idx      <= '0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_tx       <= w_tx;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_shift    <= w_shift;
            r_idx      <= w_idx;
            r_stop_cnt <= w_stop_cnt;
        end
    end

    // Frame configuration and parity are frozen at acceptance.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_par_en <= 1'b0;
            r_parity <= 1'b0;
            r_stop2  <= 1'b0;
            r_msb    <= 1'b0;
            r_pre    <= '0;
        end else if (w_accept) begin
            r_par_en <= s_bus.par_en;
            r_parity <= (^s_bus.p_data) ^ (s_bus.par_typ == PAR_ODD);
            r_stop2  <= s_bus.stop2;
            r_msb    <= s_bus.msb_first;
            r_pre    <= s_bus.prescale;
        end
    end

    assign s_bus.tx_out = r_tx;
    assign s_bus.busy   = r_busy;
    assign s_bus.done   = r_done;

endmodule
